wm_controller_param: RTL and testbench

- Parametrised successor to the automatic washing machine FSM.
- Internal duration timers replace the external cycle_timeout/spin_timeout inputs.
- Adds a configurable number of rinse passes, fill/drain watchdogs with a latched error state, and a pause qualifier.
- Sits between the panel/sensor inputs and the valve/motor drivers; one instance per machine.

---
 rtl/wm_controller_param.sv | 212 +++++++++++++++++++++
 tb/tb_wm_controller_param.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wm_controller_param.sv
// Washing machine sequencer with internal step timers, configurable rinse passes,
// fill/drain watchdogs latching an error state, and a pause qualifier.
module wm_controller_param #(
   parameter int TIMER_W       = 8,
   parameter int WASH_CYCLES   = 8,
   parameter int RINSE_CYCLES  = 6,
   parameter int SPIN_CYCLES   = 10,
   parameter int RINSE_COUNT   = 2,
   parameter int FILL_TIMEOUT  = 20,
   parameter int DRAIN_TIMEOUT = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       door_close,
   input  logic       filled,
   input  logic       detergent_added,
   input  logic       drained,
   input  logic       pause,
   output logic       door_lock,
   output logic       motor_on,
   output logic       fill_valve_on,
   output logic       drain_valve_on,
   output logic       soap_wash,
   output logic       water_wash,
   output logic       done,
   output logic       error,
   output logic       paused,
   output logic [3:0] rinse_num,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_FILL    = 4'd1,
      S_ADD_DET = 4'd2,
      S_WASH    = 4'd3,
      S_DRAIN   = 4'd4,
      S_RINSE   = 4'd5,
      S_SPIN    = 4'd6,
      S_DONE    = 4'd7,
      S_ERROR   = 4'd8
   } state_t;

   localparam logic [TIMER_W-1:0] WASH_LAST  = TIMER_W'(WASH_CYCLES - 1);
   localparam logic [TIMER_W-1:0] RINSE_LAST = TIMER_W'(RINSE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] SPIN_LAST  = TIMER_W'(SPIN_CYCLES - 1);
   localparam logic [TIMER_W-1:0] FILL_LAST  = TIMER_W'(FILL_TIMEOUT - 1);
   localparam logic [TIMER_W-1:0] DRAIN_LAST = TIMER_W'(DRAIN_TIMEOUT - 1);
   localparam logic [3:0]         RINSE_MAX  = 4'(RINSE_COUNT);

   state_t             st_q;
   logic [TIMER_W-1:0] timer_q;
   logic [3:0]         rinse_q;
   logic               active;
   logic               hold;
   logic               wash_phase;

   assign active     = st_q inside {S_FILL, S_ADD_DET, S_WASH, S_DRAIN, S_RINSE, S_SPIN};
   assign hold       = pause && active;
   assign wash_phase = (rinse_q == 4'd0);

   // A paused step freezes everything: no transition, timer held, events ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         st_q    <= S_IDLE;
         timer_q <= '0;
         rinse_q <= 4'd0;
      end else if (!hold) begin
         case (st_q)
            S_IDLE: begin
               timer_q <= '0;
               if (start && door_close) st_q <= S_FILL;
            end
            S_FILL: begin
               if (filled) begin
                  st_q    <= wash_phase ? S_ADD_DET : S_RINSE;
                  timer_q <= '0;
               end else if (timer_q == FILL_LAST) begin
                  st_q    <= S_ERROR;
                  timer_q <= '0;
               end else begin
                  timer_q <= timer_q + TIMER_W'(1);
               end
            end
            S_ADD_DET: begin
               if (detergent_added) begin
                  st_q    <= S_WASH;
                  timer_q <= '0;
               end else begin
                  timer_q <= timer_q + TIMER_W'(1);
               end
            end
            S_WASH: begin
               if (timer_q == WASH_LAST) begin
                  st_q    <= S_DRAIN;
                  timer_q <= '0;
               end else begin
                  timer_q <= timer_q + TIMER_W'(1);
               end
            end
            S_DRAIN: begin
               if (drained) begin
                  timer_q <= '0;
                  if (rinse_q < RINSE_MAX) begin
                     rinse_q <= rinse_q + 4'd1;
                     st_q    <= S_FILL;
                  end else begin
                     st_q    <= S_SPIN;
                  end
               end else if (timer_q == DRAIN_LAST) begin
                  st_q    <= S_ERROR;
                  timer_q <= '0;
               end else begin
                  timer_q <= timer_q + TIMER_W'(1);
               end
            end
            S_RINSE: begin
               if (timer_q == RINSE_LAST) begin
                  st_q    <= S_DRAIN;
                  timer_q <= '0;
               end else begin
                  timer_q <= timer_q + TIMER_W'(1);
               end
            end
            S_SPIN: begin
               if (timer_q == SPIN_LAST) begin
                  st_q    <= S_DONE;
                  timer_q <= '0;
                  rinse_q <= 4'd0;
               end else begin
                  timer_q <= timer_q + TIMER_W'(1);
               end
            end
            S_DONE: begin
               timer_q <= '0;
               if (!start) st_q <= S_IDLE;
            end
            S_ERROR: begin
               timer_q <= '0;
            end
            default: begin
               st_q    <= S_IDLE;
               timer_q <= '0;
               rinse_q <= 4'd0;
            end
         endcase
      end
   end

   always_comb begin
      door_lock      = 1'b0;
      motor_on       = 1'b0;
      fill_valve_on  = 1'b0;
      drain_valve_on = 1'b0;
      soap_wash      = 1'b0;
      water_wash     = 1'b0;
      done           = 1'b0;
      error          = 1'b0;
      case (st_q)
         S_FILL: begin
            door_lock     = 1'b1;
            fill_valve_on = 1'b1;
            soap_wash     = wash_phase;
            water_wash    = !wash_phase;
         end
         S_ADD_DET: begin
            door_lock = 1'b1;
            soap_wash = 1'b1;
         end
         S_WASH: begin
            door_lock = 1'b1;
            motor_on  = 1'b1;
            soap_wash = 1'b1;
         end
         S_DRAIN: begin
            door_lock      = 1'b1;
            drain_valve_on = 1'b1;
            soap_wash      = wash_phase;
            water_wash     = !wash_phase;
         end
         S_RINSE: begin
            door_lock  = 1'b1;
            motor_on   = 1'b1;
            water_wash = 1'b1;
         end
         S_SPIN: begin
            door_lock      = 1'b1;
            motor_on       = 1'b1;
            drain_valve_on = 1'b1;
         end
         S_DONE: done = 1'b1;
         // Keep the door shut until the tub is confirmed empty.
         S_ERROR: begin
            error          = 1'b1;
            drain_valve_on = 1'b1;
            door_lock      = !drained;
         end
         default: ;
      endcase
      if (hold) begin
         motor_on       = 1'b0;
         fill_valve_on  = 1'b0;
         drain_valve_on = 1'b0;
      end
   end

   assign paused    = hold;
   assign rinse_num = rinse_q;
   assign state     = st_q;

endmodule

// File: tb/tb_wm_controller_param.sv
// Scoreboard bench for wm_controller_param: default build plus a RINSE_COUNT=0 build.
module tb_wm_controller_param;

   logic clk = 1'b0;
   logic reset, start, door_close, filled, detergent_added, drained, pause;

   logic d_lock, d_motor, d_fill, d_drain, d_soap, d_water, d_done, d_err, d_paused;
   logic [3:0] d_rinse, d_state;
   logic z_lock, z_motor, z_fill, z_drain, z_soap, z_water, z_done, z_err, z_paused;
   logic [3:0] z_rinse, z_state;
   logic [8:0] o_d, o_z;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [3:0] st;
      logic [3:0] rn;
      logic [8:0] outs;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   wm_controller_param dut (
      .clk(clk), .reset(reset), .start(start), .door_close(door_close), .filled(filled),
      .detergent_added(detergent_added), .drained(drained), .pause(pause),
      .door_lock(d_lock), .motor_on(d_motor), .fill_valve_on(d_fill), .drain_valve_on(d_drain),
      .soap_wash(d_soap), .water_wash(d_water), .done(d_done), .error(d_err), .paused(d_paused),
      .rinse_num(d_rinse), .state(d_state)
   );

   wm_controller_param #(.RINSE_COUNT(0)) dut0 (
      .clk(clk), .reset(reset), .start(start), .door_close(door_close), .filled(filled),
      .detergent_added(detergent_added), .drained(drained), .pause(pause),
      .door_lock(z_lock), .motor_on(z_motor), .fill_valve_on(z_fill), .drain_valve_on(z_drain),
      .soap_wash(z_soap), .water_wash(z_water), .done(z_done), .error(z_err), .paused(z_paused),
      .rinse_num(z_rinse), .state(z_state)
   );

   assign o_d = {d_lock, d_motor, d_fill, d_drain, d_soap, d_water, d_done, d_err, d_paused};
   assign o_z = {z_lock, z_motor, z_fill, z_drain, z_soap, z_water, z_done, z_err, z_paused};

   // Output vector {lock,motor,fill,drain,soap,water,done,error,paused} from the state table.
   function automatic logic [8:0] exp_out(input logic [3:0] st, input logic [3:0] rn,
                                           input logic pz, input logic drn);
      logic lk, mo, fv, dv, sw, ww;
      lk = (st >= 4'd1 && st <= 4'd6) || (st == 4'd8 && !drn);
      mo = !pz && (st == 4'd3 || st == 4'd5 || st == 4'd6);
      fv = !pz && st == 4'd1;
      dv = (!pz && (st == 4'd4 || st == 4'd6)) || st == 4'd8;
      sw = st == 4'd2 || st == 4'd3 || ((st == 4'd1 || st == 4'd4) && rn == 4'd0);
      ww = st == 4'd5 || ((st == 4'd1 || st == 4'd4) && rn != 4'd0);
      return {lk, mo, fv, dv, sw, ww, st == 4'd7, st == 4'd8, pz};
   endfunction

   task automatic push_exp(input int st, input int rn, input logic pz, input logic drn, input int n);
      exp_t e;
      e.st   = 4'(st);
      e.rn   = 4'(rn);
      e.outs = exp_out(4'(st), 4'(rn), pz, drn);
      for (int i = 0; i < n; i++) sb.push_back(e);
   endtask

   task automatic clear_inputs();
      start = 0; door_close = 0; filled = 0; detergent_added = 0; drained = 0; pause = 0;
   endtask

   task automatic do_reset();
      reset = 1;
      clear_inputs();
      repeat (2) @(negedge clk);
      reset = 0;
   endtask

   task automatic test_reset();
      reset = 1;
      clear_inputs();
      pause = 1;
      start = 1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({d_state, d_rinse, o_d} !== 17'd0) begin
         n_err++;
         $display("FAIL reset_dut: got st=%0d rn=%0d out=%b, need all zero", d_state, d_rinse, o_d);
      end
      n_cmp++;
      if ({z_state, z_rinse, o_z} !== 17'd0) begin
         n_err++;
         $display("FAIL reset_dut0: got st=%0d rn=%0d out=%b, need all zero", z_state, z_rinse, o_z);
      end
      clear_inputs();
   endtask

   task automatic test_full_program();
      int sst[13]  = '{1, 2, 3, 4, 1, 5, 4, 1, 5, 4, 6, 7, 0};
      int srn[13]  = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 2, 0, 0};
      int slen[13] = '{3, 1, 8, 2, 3, 6, 2, 3, 6, 2, 10, 3, 1};
      exp_t e;
      logic [3:0] prev;
      int cnt;
      do_reset();
      start = 1; door_close = 1;
      for (int s = 0; s < 13; s++) push_exp(sst[s], srn[s], 1'b0, 1'b0, slen[s]);
      prev = 4'hF; cnt = 0;
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         n_cmp++;
         if ({d_state, d_rinse, o_d} !== {e.st, e.rn, e.outs}) begin
            n_err++;
            $display("FAIL full_program: got st=%0d rn=%0d out=%b, need st=%0d rn=%0d out=%b",
                     d_state, d_rinse, o_d, e.st, e.rn, e.outs);
         end
         cnt  = (e.st == prev) ? cnt + 1 : 1;
         prev = e.st;
         filled          = (e.st == 4'd1 && cnt == 3);
         detergent_added = (e.st == 4'd2 && cnt == 1);
         drained         = (e.st == 4'd4 && cnt == 2);
         if (e.st == 4'd7 && cnt == 3) start = 0;
      end
      clear_inputs();
   endtask

   task automatic test_no_rinse();
      int sst[6]  = '{1, 2, 3, 4, 6, 7};
      int slen[6] = '{3, 1, 8, 2, 10, 2};
      exp_t e;
      logic [3:0] prev;
      int cnt;
      do_reset();
      start = 1; door_close = 1;
      for (int s = 0; s < 6; s++) push_exp(sst[s], 0, 1'b0, 1'b0, slen[s]);
      prev = 4'hF; cnt = 0;
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         n_cmp++;
         if ({z_state, z_rinse, o_z} !== {e.st, e.rn, e.outs}) begin
            n_err++;
            $display("FAIL no_rinse: got st=%0d rn=%0d out=%b, need st=%0d rn=%0d out=%b",
                     z_state, z_rinse, o_z, e.st, e.rn, e.outs);
         end
         cnt  = (e.st == prev) ? cnt + 1 : 1;
         prev = e.st;
         filled          = (e.st == 4'd1 && cnt == 3);
         detergent_added = (e.st == 4'd2 && cnt == 1);
         drained         = (e.st == 4'd4 && cnt == 2);
      end
      clear_inputs();
   endtask

   task automatic test_pause();
      exp_t e;
      do_reset();
      start = 1; door_close = 1; filled = 1; detergent_added = 1;
      push_exp(1, 0, 1'b0, 1'b0, 1);
      push_exp(2, 0, 1'b0, 1'b0, 1);
      push_exp(3, 0, 1'b0, 1'b0, 4);
      push_exp(3, 0, 1'b1, 1'b0, 5);
      push_exp(3, 0, 1'b0, 1'b0, 4);
      push_exp(4, 0, 1'b0, 1'b0, 1);
      for (int j = 0; j < 16; j++) begin
         @(negedge clk);
         e = sb.pop_front();
         n_cmp++;
         if ({d_state, d_rinse, o_d} !== {e.st, e.rn, e.outs}) begin
            n_err++;
            $display("FAIL pause_wash obs %0d: got st=%0d out=%b, need st=%0d out=%b",
                     j, d_state, o_d, e.st, e.outs);
         end
         if (j == 5)  pause = 1;
         if (j == 10) pause = 0;
      end
      clear_inputs();
   endtask

   task automatic test_watchdog();
      exp_t e;
      do_reset();
      start = 1; door_close = 1;
      push_exp(1, 0, 1'b0, 1'b0, 20);
      push_exp(8, 0, 1'b0, 1'b0, 1);
      for (int j = 0; j < 21; j++) begin
         @(negedge clk);
         e = sb.pop_front();
         n_cmp++;
         if ({d_state, d_rinse, o_d} !== {e.st, e.rn, e.outs}) begin
            n_err++;
            $display("FAIL fill_watchdog obs %0d: got st=%0d out=%b, need st=%0d out=%b",
                     j, d_state, o_d, e.st, e.outs);
         end
      end
      drained = 1;
      #1;
      n_cmp++;
      if (o_d !== exp_out(4'd8, 4'd0, 1'b0, 1'b1)) begin
         n_err++;
         $display("FAIL error_drained_unlock: got out=%b, need out=%b", o_d, exp_out(4'd8, 4'd0, 1'b0, 1'b1));
      end
      pause = 1;
      for (int j = 0; j < 4; j++) begin
         start = ~start;
         @(negedge clk);
         n_cmp++;
         if ({d_state, o_d} !== {4'd8, exp_out(4'd8, 4'd0, 1'b0, 1'b1)}) begin
            n_err++;
            $display("FAIL error_sticky %0d: got st=%0d out=%b, need st=8 out=%b",
                     j, d_state, o_d, exp_out(4'd8, 4'd0, 1'b0, 1'b1));
         end
      end
      reset = 1;
      @(negedge clk);
      n_cmp++;
      if ({d_state, d_rinse, o_d} !== 17'd0) begin
         n_err++;
         $display("FAIL error_reset: got st=%0d rn=%0d out=%b, need all zero", d_state, d_rinse, o_d);
      end
      reset = 0;
      clear_inputs();
   endtask

   task automatic test_fill_race();
      exp_t e;
      do_reset();
      start = 1; door_close = 1;
      push_exp(1, 0, 1'b0, 1'b0, 20);
      push_exp(2, 0, 1'b0, 1'b0, 1);
      for (int j = 0; j < 21; j++) begin
         @(negedge clk);
         e = sb.pop_front();
         n_cmp++;
         if ({d_state, d_rinse, o_d} !== {e.st, e.rn, e.outs}) begin
            n_err++;
            $display("FAIL fill_race obs %0d: got st=%0d out=%b, need st=%0d out=%b",
                     j, d_state, o_d, e.st, e.outs);
         end
         filled = (j == 19);
      end
      do_reset();
      start = 1; door_close = 0;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         n_cmp++;
         if ({d_state, d_rinse, o_d} !== 17'd0) begin
            n_err++;
            $display("FAIL idle_door_open %0d: got st=%0d rn=%0d out=%b, need all zero",
                     j, d_state, d_rinse, o_d);
         end
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid_rinse();
      exp_t e;
      do_reset();
      start = 1; door_close = 1; filled = 1; detergent_added = 1; drained = 1;
      push_exp(1, 0, 1'b0, 1'b1, 1);
      push_exp(2, 0, 1'b0, 1'b1, 1);
      push_exp(3, 0, 1'b0, 1'b1, 8);
      push_exp(4, 0, 1'b0, 1'b1, 1);
      push_exp(1, 1, 1'b0, 1'b1, 1);
      push_exp(5, 1, 1'b0, 1'b1, 2);
      for (int j = 0; j < 14; j++) begin
         @(negedge clk);
         e = sb.pop_front();
         n_cmp++;
         if ({d_state, d_rinse, o_d} !== {e.st, e.rn, e.outs}) begin
            n_err++;
            $display("FAIL to_rinse obs %0d: got st=%0d rn=%0d out=%b, need st=%0d rn=%0d out=%b",
                     j, d_state, d_rinse, o_d, e.st, e.rn, e.outs);
         end
      end
      reset = 1;
      @(negedge clk);
      n_cmp++;
      if ({d_state, d_rinse, o_d} !== 17'd0) begin
         n_err++;
         $display("FAIL reset_mid_rinse: got st=%0d rn=%0d out=%b, need all zero", d_state, d_rinse, o_d);
      end
      reset = 0;
      clear_inputs();
   endtask

   initial begin
      #200us;
      $display("FAIL time_limit: bench still running at 200us");
      $fatal(1, "time limit");
   end

   initial begin
      reset = 1;
      clear_inputs();
      @(negedge clk);
      test_reset();
      test_full_program();
      test_no_rinse();
      test_pause();
      test_watchdog();
      test_fill_race();
      test_reset_mid_rinse();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
